// File: rtl/mips_mc_controller_pkg.sv
// Shared encodings for the multicycle MIPS control sequencer: opcodes,
// funct codes, ALU op classes and control codes, datapath select codes
// and the FSM state encoding.
package mips_mc_controller_pkg;

  // Opcodes recognised by the sequencer (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation class requested by the sequencer; 2'b11 is never issued
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  // ALU control codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Next-PC source select
  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // ALU B operand select
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // FSM state encoding; codes 12..15 are unreachable and recover to FETCH
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  // True when the opcode has an execution path through the FSM
  function automatic logic op_supported(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mips_mc_controller_if.sv
// Control bundle between the multicycle sequencer and its datapath/memory.
// master = sequencer (drives controls, observes instruction fields and status),
// slave  = datapath side.
interface mips_mc_controller_if;

  // Instruction fields and datapath/memory status
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;

  // Memory handshake and datapath controls
  logic       mem_req;
  logic       memwrite;
  logic       iord;
  logic       irwrite;
  logic       pcen;
  logic [1:0] pcsrc;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [2:0] alucontrol;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       retire;
  logic       illegal;

  modport master (
    input  op, funct, zero, mem_ready,
    output mem_req, memwrite, iord, irwrite, pcen, pcsrc, alusrca, alusrcb,
           alucontrol, regdst, memtoreg, regwrite, retire, illegal
  );

  modport slave (
    output op, funct, zero, mem_ready,
    input  mem_req, memwrite, iord, irwrite, pcen, pcsrc, alusrca, alusrcb,
           alucontrol, regdst, memtoreg, regwrite, retire, illegal
  );

endinterface

// File: rtl/mips_mc_controller_alu_decoder.sv
// ALU control decode: maps the sequencer's op class plus funct to an ALU code.
// Purely combinational, zero latency, no flow control.
module mips_mc_controller_alu_decoder
  import mips_mc_controller_pkg::*;
(
  input  aluop_t     aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  // Fixed add/sub for address and branch math; funct decides for R-type
  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// Moore sequencer for the multicycle MIPS core: FETCH/DECODE/EXEC/MEM/WB.
// Latency: 3-5 cycles per instruction plus one per cycle memory is not ready.
// Memory backpressure: FETCH/MEMRD/MEMWR hold with stable request until mem_ready.
module mips_mc_controller
  import mips_mc_controller_pkg::*;
#(
  parameter int MEM_HANDSHAKE = 1,
  parameter int STATEBITS     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  mips_mc_controller_if.master bus
);

  typedef logic [STATEBITS-1:0] sreg_t;

  localparam sreg_t ST_FETCH   = sreg_t'(S_FETCH);
  localparam sreg_t ST_DECODE  = sreg_t'(S_DECODE);
  localparam sreg_t ST_MEMADR  = sreg_t'(S_MEMADR);
  localparam sreg_t ST_MEMRD   = sreg_t'(S_MEMRD);
  localparam sreg_t ST_MEMWB   = sreg_t'(S_MEMWB);
  localparam sreg_t ST_MEMWR   = sreg_t'(S_MEMWR);
  localparam sreg_t ST_RTYPEEX = sreg_t'(S_RTYPEEX);
  localparam sreg_t ST_RTYPEWB = sreg_t'(S_RTYPEWB);
  localparam sreg_t ST_BEQEX   = sreg_t'(S_BEQEX);
  localparam sreg_t ST_ADDIEX  = sreg_t'(S_ADDIEX);
  localparam sreg_t ST_ADDIWB  = sreg_t'(S_ADDIWB);
  localparam sreg_t ST_JEX     = sreg_t'(S_JEX);

  sreg_t      state_q;
  sreg_t      state_d;
  logic       rdy;
  aluop_t     aluop;

  logic       mem_req;
  logic       memwrite;
  logic       iord;
  logic       irwrite;
  logic       pcen;
  logic [1:0] pcsrc;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic       regdst;
  logic       memtoreg;
  logic       regwrite;
  logic       retire;
  logic       illegal;

  // A single-cycle memory build treats every access as completing at once
  assign rdy = (MEM_HANDSHAKE != 0) ? bus.mem_ready : 1'b1;

  // State register: the only storage in the sequencer
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_FETCH;
    else     state_q <= state_d;
  end

  // Next-state: memory states wait on rdy, everything else advances each cycle
  always_comb begin
    state_d = ST_FETCH;
    case (state_q)
      ST_FETCH:  state_d = rdy ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_RTYPE:     state_d = ST_RTYPEEX;
          OP_BEQ:       state_d = ST_BEQEX;
          OP_ADDI:      state_d = ST_ADDIEX;
          OP_J:         state_d = ST_JEX;
          default:      state_d = ST_FETCH;
        endcase
      end
      ST_MEMADR:  state_d = (bus.op == OP_SW) ? ST_MEMWR : ST_MEMRD;
      ST_MEMRD:   state_d = rdy ? ST_MEMWB : ST_MEMRD;
      ST_MEMWB:   state_d = ST_FETCH;
      ST_MEMWR:   state_d = rdy ? ST_FETCH : ST_MEMWR;
      ST_RTYPEEX: state_d = ST_RTYPEWB;
      ST_RTYPEWB: state_d = ST_FETCH;
      ST_BEQEX:   state_d = ST_FETCH;
      ST_ADDIEX:  state_d = ST_ADDIWB;
      ST_ADDIWB:  state_d = ST_FETCH;
      ST_JEX:     state_d = ST_FETCH;
      default:    state_d = ST_FETCH;
    endcase
  end

  // Output decode from state; reset masks every enable and pulse so an
  // in-flight write or register update cannot commit
  always_comb begin
    mem_req  = 1'b0;
    memwrite = 1'b0;
    iord     = 1'b0;
    irwrite  = 1'b0;
    pcen     = 1'b0;
    pcsrc    = PC_ALU;
    alusrca  = 1'b0;
    alusrcb  = SRCB_REG;
    aluop    = ALUOP_ADD;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    regwrite = 1'b0;
    retire   = 1'b0;
    illegal  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_req = 1'b1;
        alusrcb = SRCB_FOUR;
        irwrite = rdy;
        pcen    = rdy;
      end
      ST_DECODE: begin
        alusrcb = SRCB_IMMSH;
        illegal = !op_supported(bus.op);
      end
      ST_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      ST_MEMRD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      ST_MEMWB: begin
        memtoreg = 1'b1;
        regwrite = 1'b1;
        retire   = 1'b1;
      end
      ST_MEMWR: begin
        mem_req  = 1'b1;
        memwrite = 1'b1;
        iord     = 1'b1;
        retire   = rdy;
      end
      ST_RTYPEEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      ST_RTYPEWB: begin
        regdst   = 1'b1;
        regwrite = 1'b1;
        retire   = 1'b1;
      end
      ST_BEQEX: begin
        alusrca = 1'b1;
        aluop   = ALUOP_SUB;
        pcsrc   = PC_ALUOUT;
        pcen    = bus.zero;
        retire  = 1'b1;
      end
      ST_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
      end
      ST_ADDIWB: begin
        regwrite = 1'b1;
        retire   = 1'b1;
      end
      ST_JEX: begin
        pcsrc  = PC_JUMP;
        pcen   = 1'b1;
        retire = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      mem_req  = 1'b0;
      memwrite = 1'b0;
      irwrite  = 1'b0;
      pcen     = 1'b0;
      regwrite = 1'b0;
      retire   = 1'b0;
      illegal  = 1'b0;
    end
  end

  mips_mc_controller_alu_decoder u_alu_dec (
    .aluop      (aluop),
    .funct      (bus.funct),
    .alucontrol (bus.alucontrol)
  );

  assign bus.mem_req  = mem_req;
  assign bus.memwrite = memwrite;
  assign bus.iord     = iord;
  assign bus.irwrite  = irwrite;
  assign bus.pcen     = pcen;
  assign bus.pcsrc    = pcsrc;
  assign bus.alusrca  = alusrca;
  assign bus.alusrcb  = alusrcb;
  assign bus.regdst   = regdst;
  assign bus.memtoreg = memtoreg;
  assign bus.regwrite = regwrite;
  assign bus.retire   = retire;
  assign bus.illegal  = illegal;

endmodule
